// File: rtl/cfg_wr_arb_pkg.sv
// cfg_wr_arb_pkg: shared lock-state encoding and round-robin priority select for cfg_wr_arb.
package cfg_wr_arb_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic {UNLOCKED, LOCKED} lock_e;

    // One-hot pick of the first set request at or after ptr, wrapping at ports.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [3:0]           ptr,
        input logic [4:0]           ports
    );
        logic [4:0] idx;
        rr_pick = '0;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            idx = 5'(ptr) + 5'(k);
            idx = (idx >= ports) ? idx - ports : idx;
            if (k < int'(ports) && req[idx[3:0]]) begin
                rr_pick = '0;
                rr_pick[idx[3:0]] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/cfg_wr_rr_arb.sv
// cfg_wr_rr_arb: round-robin request/grant with pointer register; define CFG_WR_ARB_LOCK_EN
// to hold the grant on one port until its last beat is accepted.
module cfg_wr_rr_arb
    import cfg_wr_arb_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS-1:0]           req_i,
    input  logic                       accept_i,
    input  logic                       last_i,
    output logic [PORTS-1:0]           grant_o,
    output logic [$clog2(PORTS)-1:0]   idx_o
);

    localparam int IW = $clog2(PORTS);

    logic [IW-1:0]        ptr_q, ptr_d;
    logic [MAX_PORTS-1:0] pick;
    logic [PORTS-1:0]     grant_raw;

    always_comb pick = rr_pick(MAX_PORTS'(req_i), 4'(ptr_q), 5'(PORTS));

`ifdef CFG_WR_ARB_LOCK_EN
    lock_e         lock_q, lock_d;
    logic [IW-1:0] lidx_q, lidx_d;

    always_comb begin
        grant_raw = (lock_q == LOCKED) ? (req_i & (PORTS'(1) << lidx_q)) : pick[PORTS-1:0];
        lock_d    = accept_i ? (last_i ? UNLOCKED : LOCKED) : lock_q;
        lidx_d    = accept_i ? idx_o : lidx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= UNLOCKED;
            lidx_q <= '0;
        end else begin
            lock_q <= lock_d;
            lidx_q <= lidx_d;
        end
    end
`else
    logic unused_last;

    always_comb begin
        grant_raw   = pick[PORTS-1:0];
        unused_last = last_i;
    end
`endif

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < PORTS; i++)
            if (grant_raw[i]) idx_o = IW'(i);
    end

    always_comb begin
        grant_o = rst_n ? grant_raw : '0;
        ptr_d   = accept_i ? ((idx_o == IW'(PORTS - 1)) ? '0 : IW'(idx_o + 1'b1)) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cfg_wr_arb.sv
// cfg_wr_arb: arbitrates PORTS config-write requesters onto one registered write port;
// CFG_WR_ARB_LOCK_EN enables locked multi-beat sequences via s_req_last.
module cfg_wr_arb
    import cfg_wr_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS-1:0]            s_req_valid,
    output logic [PORTS-1:0]            s_req_ready,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] s_req_data,
    input  logic [PORTS*STRB_WIDTH-1:0] s_req_strb,
    input  logic [PORTS-1:0]            s_req_last,
    output logic                        wr,
    output logic [ADDR_WIDTH-1:0]       waddr,
    output logic [DATA_WIDTH-1:0]       wdata,
    output logic [STRB_WIDTH-1:0]       wstrb,
    input  logic                        wr_ready,
    output logic [PORTS-1:0]            grant
);

    logic [$clog2(PORTS)-1:0] idx;
    logic                     load, accept;
    logic                     wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]    waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;

    cfg_wr_rr_arb #(.PORTS(PORTS)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (s_req_valid),
        .accept_i (accept),
        .last_i   (s_req_last[idx]),
        .grant_o  (grant),
        .idx_o    (idx)
    );

    // The output register may take a new beat whenever it is empty or draining this cycle.
    always_comb begin
        load        = !wr_q || wr_ready;
        s_req_ready = grant & {PORTS{load}};
        accept      = |s_req_ready;
        wr_d        = accept | (wr_q & !wr_ready);
        waddr_d     = accept ? s_req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] : waddr_q;
        wdata_d     = accept ? s_req_data[idx*DATA_WIDTH +: DATA_WIDTH] : wdata_q;
        wstrb_d     = accept ? s_req_strb[idx*STRB_WIDTH +: STRB_WIDTH] : wstrb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        wr    = wr_q;
        waddr = waddr_q;
        wdata = wdata_q;
        wstrb = wstrb_q;
    end

endmodule

// File: tb/tb_cfg_wr_arb.sv
// tb_cfg_wr_arb: vector table, corner-case sequences and a randomized run against a
// queue-based reference model; lock expectations follow CFG_WR_ARB_LOCK_EN.
module tb_cfg_wr_arb;

    localparam int P  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P-1:0]    s_req_valid, s_req_ready, s_req_last, grant;
    logic [P*AW-1:0] s_req_addr;
    logic [P*DW-1:0] s_req_data;
    logic [P*SW-1:0] s_req_strb;
    logic            wr, wr_ready;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [SW-1:0]   wstrb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    typedef struct {
        logic [P-1:0] v;
        logic         rdy;
        logic [P-1:0] g;
        logic [P-1:0] r;
        logic         w;
        logic [AW-1:0] a;
    } vec_t;

    wr_t q[$];
    int  m_ptr;
    bit  m_locked;
    int  m_lidx;

    always #5 clk = ~clk;

    cfg_wr_arb #(.PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_addr  (s_req_addr),
        .s_req_data  (s_req_data),
        .s_req_strb  (s_req_strb),
        .s_req_last  (s_req_last),
        .wr          (wr),
        .waddr       (waddr),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wr_ready    (wr_ready),
        .grant       (grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic set_defaults();
        for (int i = 0; i < P; i++) begin
            s_req_addr[i*AW +: AW] = 32'h10 + 32'(8 * i);
            s_req_data[i*DW +: DW] = 32'hA000 + 32'(i);
            s_req_strb[i*SW +: SW] = 4'(i + 1);
        end
        s_req_last = '1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        wr_ready    = 1'b0;
        s_req_valid = '1;
        @(negedge clk);
        chk("reset wr", wr, 0);
        chk("reset waddr", waddr, 0);
        chk("reset wdata", wdata, 0);
        chk("reset wstrb", wstrb, 0);
        chk("reset grant", grant, 0);
        chk("reset ready", s_req_ready, 0);
        s_req_valid = '0;
        @(negedge clk);
        rst_n    = 1'b1;
        q.delete();
        m_ptr    = 0;
        m_locked = 0;
        m_lidx   = 0;
    endtask

    // Reference arbitration: first valid port scanning from the pointer, or the locked port.
    function automatic logic [P-1:0] model_grant(input logic [P-1:0] v);
        if (m_locked) return v[m_lidx] ? P'(1) << m_lidx : '0;
        for (int k = 0; k < P; k++) begin
            int p = (m_ptr + k) % P;
            if (v[p]) return P'(1) << p;
        end
        return '0;
    endfunction

    initial begin
        vec_t          tbl[10];
        logic [15:0]   order;
        int            beats, nacc, cyc;
        bit            p0pend, p0done;
        logic [P-1:0]  eg, er;
        logic [3:0]    exp_g[5];

        s_req_valid = '0;
        wr_ready    = 1'b0;
        set_defaults();

        tbl = '{
            '{4'b0101, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'h10},
            '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 32'h20},
            '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h20},
            '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 32'h28},
            '{4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b1, 32'h28},
            '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 32'h28},
            '{4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 32'h18},
            '{4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'h10},
            '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h10},
            '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h10}
        };

        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_req_valid = tbl[i].v;
            wr_ready    = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d ready", i), s_req_ready, tbl[i].r);
            @(negedge clk);
            chk($sformatf("tbl%0d wr", i), wr, tbl[i].w);
            chk($sformatf("tbl%0d waddr", i), waddr, tbl[i].a);
        end

        // All ports continuously valid: rotating grant, one write per cycle
        do_reset();
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        s_req_valid = '1;
        wr_ready    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d grant", k), grant, exp_g[k]);
            @(negedge clk);
            chk($sformatf("rr%0d wr", k), wr, 1);
            chk($sformatf("rr%0d waddr", k), waddr, 32'h10 + 32'(8 * (k % P)));
        end
        s_req_valid = '0;
        @(negedge clk);
        chk("rr drain wr", wr, 0);

        // Backpressure: output held stable for 5 stalled cycles, then one completion
        s_req_valid = 4'b0010;
        wr_ready    = 1'b0;
        @(negedge clk);
        s_req_data[1*DW +: DW] = 32'h5555;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall ready", s_req_ready, 0);
            @(negedge clk);
            chk("stall wr", wr, 1);
            chk("stall waddr", waddr, 32'h18);
            chk("stall wdata", wdata, 32'hA001);
        end
        s_req_valid = '0;
        wr_ready    = 1'b1;
        #1;
        chk("stall complete", wr && wr_ready, 1);
        @(negedge clk);
        chk("stall done wr", wr, 0);
        set_defaults();

        // Async reset while a write is pending discards it
        s_req_data[0 +: DW] = 32'hDEADBEEF;
        s_req_valid = 4'b0001;
        wr_ready    = 1'b0;
        @(negedge clk);
        chk("pre-rst wdata", wdata, 32'hDEADBEEF);
        s_req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst wr", wr, 0);
        chk("async rst wdata", wdata, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post-rst no write", wr, 0);
            @(negedge clk);
        end
        set_defaults();

        // Port3 three-beat sequence racing port0
        do_reset();
        wr_ready = 1'b1;
        beats = 3; nacc = 0; cyc = 0; order = '0; p0pend = 0; p0done = 0;
        while ((beats > 0 || !p0done) && cyc < 20) begin
            if (cyc == 1) p0pend = 1;
            s_req_valid = {beats > 0, 2'b00, p0pend};
            s_req_last  = {beats == 1, 3'b111};
            s_req_addr[3*AW +: AW] = 32'h300 + 32'(3 - beats);
            #1;
            if (s_req_ready[3]) begin
                order = {order[11:0], 4'h3};
                beats--;
                nacc++;
            end else if (s_req_ready[0]) begin
                order = {order[11:0], 4'h0};
                p0pend = 0;
                p0done = 1;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        s_req_valid = '0;
`ifdef CFG_WR_ARB_LOCK_EN
        chk("lock order", order, 16'h3330);
`else
        chk("lock order", order, 16'h3033);
`endif
        chk("lock accepts", nacc, 4);
        chk("lock cycles", cyc, 4);
        set_defaults();

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            chk("rnd wr", wr, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd waddr", waddr, q[0].a);
                chk("rnd wdata", wdata, q[0].d);
                chk("rnd wstrb", wstrb, q[0].s);
            end
            s_req_valid = P'($urandom);
            s_req_last  = P'($urandom);
            wr_ready    = ($urandom % 4) != 0;
            for (int i = 0; i < P; i++) begin
                s_req_addr[i*AW +: AW] = $urandom;
                s_req_data[i*DW +: DW] = $urandom;
                s_req_strb[i*SW +: SW] = SW'($urandom);
            end
            #1;
            eg = model_grant(s_req_valid);
            er = (q.size() == 0 || wr_ready) ? eg : '0;
            chk("rnd grant", grant, eg);
            chk("rnd ready", s_req_ready, er);
            if (q.size() != 0 && wr_ready) void'(q.pop_front());
            for (int p = 0; p < P; p++) begin
                if (er[p]) begin
                    q.push_back('{s_req_addr[p*AW +: AW], s_req_data[p*DW +: DW], s_req_strb[p*SW +: SW]});
                    m_ptr = (p + 1) % P;
`ifdef CFG_WR_ARB_LOCK_EN
                    m_locked = !s_req_last[p];
                    m_lidx   = p;
`endif
                end
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
